// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_pkg
// Brief   : Shared state encoding and opcode constants for the fetch sequencer
// Revision: 1.0
// ============================================================================
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_FETCH_IMM = 2'd1,
        ST_INT_SAVE  = 2'd2,
        ST_INT_VEC   = 2'd3
    } state_t;

    localparam logic [3:0] OPC_EXT    = 4'hC;
    localparam logic [3:0] OPC_RETFAM = 4'hB;
    localparam logic [1:0] RA_RTI     = 2'b11;

    function automatic logic is_rti(input logic [3:0] opc, input logic [1:0] ra_f);
        return (opc == OPC_RETFAM) && (ra_f == RA_RTI);
    endfunction

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : irq_prio_enc
// Brief   : Fixed-priority encoder, lowest set index wins
// Revision: 1.0
// ============================================================================
module irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int IRQW    = 3
) (
    input  logic [NUM_IRQ-1:0] pending,
    output logic               valid,
    output logic [IRQW-1:0]    index,
    output logic [NUM_IRQ-1:0] onehot
);

    // Scan high to low so the lowest set bit is the last assignment made.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                valid     = 1'b1;
                index     = IRQW'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/ctrl_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_seq_fsm
// Brief   : Fetch/immediate/interrupt sequencer driving PC and IF/ID enables
// Revision: 1.0
// ============================================================================
module ctrl_seq_fsm
    import ctrl_pkg::*;
#(
    parameter int NUM_IRQ   = 4,
    parameter int IMM_BYTES = 1,
    parameter int IRQW      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         opcode,
    input  logic [1:0]         ra,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               stall_ext,
    input  logic               flush,
    output logic               PC_Write_En,
    output logic               IF_ID_Write_En,
    output logic               Inject_Bubble,
    output logic               Inject_Int,
    output logic               Vec_Sel,
    output logic [IRQW-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_isr
);

    localparam int CNT_W = $clog2(IMM_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IMM_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_isr_q, in_isr_d;
    logic [IRQW-1:0]    irq_id_q, irq_id_d;
    logic [NUM_IRQ-1:0] irq_oh_q, irq_oh_d;

    logic [NUM_IRQ-1:0] w_pending;
    logic               w_pend_valid;
    logic [IRQW-1:0]    w_pend_idx;
    logic [NUM_IRQ-1:0] w_pend_oh;

    assign w_pending = irq & irq_mask & {NUM_IRQ{~in_isr_q}};

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IRQW    (IRQW)
    ) u_prio (
        .pending (w_pending),
        .valid   (w_pend_valid),
        .index   (w_pend_idx),
        .onehot  (w_pend_oh)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            cnt_q    <= '0;
            in_isr_q <= 1'b0;
            irq_id_q <= '0;
            irq_oh_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_isr_q <= in_isr_d;
            irq_id_q <= irq_id_d;
            irq_oh_q <= irq_oh_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        in_isr_d       = in_isr_q;
        irq_id_d       = irq_id_q;
        irq_oh_d       = irq_oh_q;
        PC_Write_En    = 1'b0;
        IF_ID_Write_En = 1'b0;
        Inject_Bubble  = 1'b0;
        Inject_Int     = 1'b0;
        Vec_Sel        = 1'b0;
        irq_ack        = '0;

        case (state_q)
            ST_FETCH: begin
                if (stall_ext) begin
                    Inject_Bubble = 1'b1;
                end else begin
                    PC_Write_En    = 1'b1;
                    IF_ID_Write_En = 1'b1;
                    if (!flush) begin
                        if (is_rti(opcode, ra)) begin
                            in_isr_d = 1'b0;
                        end
                        // in_isr is raised on the entry edge so pending is masked
                        // for the whole atomic save/vector sequence.
                        if (opcode == OPC_EXT) begin
                            state_d = ST_FETCH_IMM;
                            cnt_d   = CNT_LOAD;
                        end else if (w_pend_valid) begin
                            state_d  = ST_INT_SAVE;
                            irq_id_d = w_pend_idx;
                            irq_oh_d = w_pend_oh;
                            in_isr_d = 1'b1;
                        end
                    end
                end
            end
            ST_FETCH_IMM: begin
                PC_Write_En   = 1'b1;
                Inject_Bubble = 1'b1;
                if (flush) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_INT_SAVE: begin
                Inject_Int = 1'b1;
                irq_ack    = irq_oh_q;
                state_d    = ST_INT_VEC;
            end
            ST_INT_VEC: begin
                PC_Write_En   = 1'b1;
                Vec_Sel       = 1'b1;
                Inject_Bubble = 1'b1;
                state_d       = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // While reset is held the pipeline is frozen with a bubble in ID/EX.
        if (rst) begin
            PC_Write_En    = 1'b0;
            IF_ID_Write_En = 1'b0;
            Inject_Bubble  = 1'b1;
            Inject_Int     = 1'b0;
            Vec_Sel        = 1'b0;
            irq_ack        = '0;
        end
    end

    assign irq_id = irq_id_q;
    assign in_isr = in_isr_q;

endmodule : ctrl_seq_fsm
`default_nettype wire

// File: doc/ctrl_seq_fsm.md
# ctrl_seq_fsm

Parametrised fetch/interrupt sequencer for the 8-bit pipelined core. It generalises the control unit's stall FSM in three ways: a configurable number of immediate bytes after an extended opcode, a prioritised multi-source maskable interrupt controller, and non-nesting interrupt service tracked until RTI. It sits beside the instruction decoder, driving the PC/IF-ID enables and the bubble and phantom-interrupt injection into the ID stage.

## Interface
- NUM_IRQ, 4, number of interrupt sources (1..8)
- IMM_BYTES, 1, immediate bytes following an extended opcode (1..3)
- IRQW, 3, width of irq_id (≥ clog2(NUM_IRQ), min 1)

- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- opcode  in  4  opcode field of IF/ID instruction
- ra  in  2  ra field of IF/ID instruction
- irq  in  NUM_IRQ  level interrupt requests
- irq_mask  in  NUM_IRQ  1 = source enabled
- stall_ext  in  1  load-use stall from hazard unit
- flush  in  1  taken branch; IF/ID content is invalid this cycle
- PC_Write_En  out  1  PC update enable
- IF_ID_Write_En  out  1  IF/ID register enable
- Inject_Bubble  out  1  force NOP into ID/EX
- Inject_Int  out  1  phantom interrupt push (decoder drives MemWrite/SP_EN/IS_CALL)
- Vec_Sel  out  1  PC source = vector table entry irq_id
- irq_id  out  IRQW  index of serviced source, held until next entry
- irq_ack  out  NUM_IRQ  one-hot acknowledge pulse
- in_isr  out  1  interrupt service in progress

## Operation
- States: FETCH, FETCH_IMM, INT_SAVE, INT_VEC. Moore outputs from state; FETCH also depends on stall_ext.
- Extended opcode: opcode == 4'hC (any ra). RTI: opcode == 4'hB and ra == 2'b11.
- pending = irq & irq_mask & {NUM_IRQ{~in_isr}}; winner = lowest set index.
- FETCH, priority order: stall_ext → stay, outputs PC=0, IFID=0, Bubble=1; else flush → stay, normal outputs, no detection; else extended → FETCH_IMM, cnt←IMM_BYTES; else pending≠0 → INT_SAVE, latch irq_id; else stay. Normal outputs: PC=1, IFID=1, others 0.
- RTI decoded in FETCH (not stall_ext, not flush) clears in_isr at the clock edge.
- FETCH_IMM: PC=1, IFID=0, Bubble=1; cnt decrements each cycle; cnt==1 → FETCH. flush → FETCH immediately, cnt←0. stall_ext ignored.
- INT_SAVE (1 cycle): PC=0, IFID=0, Inject_Int=1, irq_ack[irq_id]=1; in_isr←1 on entry edge → INT_VEC.
- INT_VEC (1 cycle): PC=1, Vec_Sel=1, IFID=0, Bubble=1 → FETCH.
- Interrupt sequence is atomic: flush, stall_ext, irq changes ignored in INT_SAVE/INT_VEC.
- Sources deasserting before entry are never acknowledged; no latching of pulses.

## Timing
- Reset (async): state FETCH, cnt 0, in_isr 0, irq_id 0; while rst=1 outputs PC=0, IFID=0, Bubble=1, Inject_Int=0, Vec_Sel=0, irq_ack=0.
- Extended opcode: exactly IMM_BYTES stall cycles, then FETCH.
- Interrupt latency: pending in FETCH at edge N → INT_SAVE during cycle N+1, INT_VEC N+2, FETCH N+3.
- Extended opcode and pending together: FETCH_IMM first; interrupt re-evaluated on return.
- RTI and pending same cycle: in_isr still 1, no entry; entry next FETCH cycle if still pending.
- Reset mid-sequence: immediate abort to reset values; no irq_ack completes.

## Structure
- Package ctrl_pkg: state enum, OPC_EXT=4'hC, OPC_RETFAM=4'hB, RA_RTI=2'b11.
- Sub-module irq_prio_enc (NUM_IRQ, IRQW): pending vector → valid, index, one-hot.
- cnt width clog2(IMM_BYTES+1).

## Test plan
- Reset held 2 cycles, release, opcode=0 → PC=1, IFID=1, Bubble=0, in_isr=0 from first FETCH cycle.
- IMM_BYTES=3, opcode=4'hC → IFID=0, Bubble=1 for exactly 3 cycles, then IFID=1.
- irq=4'b1010, mask=4'b1111 → INT_SAVE with irq_id=1, irq_ack=4'b0010, Inject_Int=1; INT_VEC Vec_Sel=1; in_isr=1.
- in_isr=1, irq[0]=1 → no entry; opcode=4'hB ra=2'b11 → in_isr=0, INT_SAVE follows with irq_id=0.
- opcode=4'hC with stall_ext=1 for 2 cycles → no FETCH_IMM entry until stall_ext=0; flush in 2nd FETCH_IMM cycle → FETCH next.
- rst asserted during INT_SAVE → async return to reset values; irq_ack=0 thereafter.
